// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RGMII receive framer.
// No logic; no latency; no backpressure.
// Holds the framer state encoding and the Ethernet CRC-32 constants.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP,
        ST_CHECK
    } rx_state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [3:0]  PRE_NIB     = 4'h5;
    localparam logic [3:0]  SFD_NIB     = 4'hD;

endpackage

// File: rtl/crc32_nib.sv
// Reflected CRC-32 update for one nibble, LSB first.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to register the result.
module crc32_nib
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 4; i++) begin
            crc_out = (crc_out >> 1) ^ (((crc_out[0] ^ nib[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII 10/100 receive framer: strips preamble, builds bytes, checks FCS/length into a ring.
// Each byte is written the cycle after its high nibble; status pulses two cycles after RX_DV falls.
// No backpressure on the line: a full ring aborts the frame. RX_MAC_FILTER_EN adds the DA filter.
module rgmii_rx_framer
    import eth_rx_pkg::*;
#(
    parameter int          ADDR_W    = 11,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic              rxclk,
    input  logic              rst_n,
    input  logic              rxctl,
    input  logic [3:0]        rxd,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frm_done,
    output logic              frm_ok,
    output logic [10:0]       frm_len,
    output logic [ADDR_W-1:0] frm_base,
    output logic [15:0]       err_cnt
);

    rx_state_t         state, state_nxt;
    logic [31:0]       crc, crc_upd;
    logic [10:0]       len;
    logic              phase;
    logic [3:0]        low_nib;
    logic [ADDR_W-1:0] wr_ptr, base, wr_ptr_inc;
    logic              ovf, bad, quiet;

    logic frm_start, sfd, crc_en, latch_low, wr_go;
    logic set_ovf, set_bad, set_quiet, rewind, report;
    logic full, len_max, good, mac_drop;

    crc32_nib u_crc (
        .crc_in  (crc),
        .nib     (rxd),
        .crc_out (crc_upd)
    );

    assign wr_ptr_inc = wr_ptr + 1'b1;
    assign full       = (wr_ptr_inc == rd_ptr);
    assign len_max    = (len == 11'(MAX_LEN));
    assign good       = !bad && !ovf && !phase && (crc == CRC_RESIDUE) &&
                        (len >= 11'(MIN_LEN)) && (len <= 11'(MAX_LEN));

`ifdef RX_MAC_FILTER_EN
    // Running match flags for unicast-to-us and broadcast over DA bytes 0..5.
    logic       uc_m, bc_m, uc_nxt, bc_nxt;
    logic [7:0] mac_b;

    always_comb begin
        case (len[2:0])
            3'd0:    mac_b = LOCAL_MAC[47:40];
            3'd1:    mac_b = LOCAL_MAC[39:32];
            3'd2:    mac_b = LOCAL_MAC[31:24];
            3'd3:    mac_b = LOCAL_MAC[23:16];
            3'd4:    mac_b = LOCAL_MAC[15:8];
            default: mac_b = LOCAL_MAC[7:0];
        endcase
        uc_nxt   = uc_m && ({rxd, low_nib} == mac_b);
        bc_nxt   = bc_m && ({rxd, low_nib} == 8'hFF);
        mac_drop = (len == 11'd5) && !uc_nxt && !bc_nxt;
    end

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            uc_m <= 1'b1;
            bc_m <= 1'b1;
        end else if (sfd) begin
            uc_m <= 1'b1;
            bc_m <= 1'b1;
        end else if (wr_go && (len < 11'd6)) begin
            uc_m <= uc_nxt;
            bc_m <= bc_nxt;
        end
    end
`else
    logic unused_mac;
    assign unused_mac = ^LOCAL_MAC;
    assign mac_drop   = 1'b0;
`endif

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frm_start = 1'b0;
        sfd       = 1'b0;
        crc_en    = 1'b0;
        latch_low = 1'b0;
        wr_go     = 1'b0;
        set_ovf   = 1'b0;
        set_bad   = 1'b0;
        set_quiet = 1'b0;
        rewind    = 1'b0;
        report    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rxctl) begin
                    if (rxd == PRE_NIB) begin
                        state_nxt = ST_PRE;
                        frm_start = 1'b1;
                    end else begin
                        state_nxt = ST_DROP;
                        set_quiet = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (!rxctl) begin
                    state_nxt = ST_IDLE;
                end else if (rxd == SFD_NIB) begin
                    state_nxt = ST_DATA;
                    sfd       = 1'b1;
                end else if (rxd != PRE_NIB) begin
                    state_nxt = ST_DROP;
                    set_bad   = 1'b1;
                end
            end
            ST_DATA: begin
                if (!rxctl) begin
                    state_nxt = ST_CHECK;
                end else begin
                    crc_en = 1'b1;
                    if (!phase) begin
                        latch_low = 1'b1;
                    end else if (len_max) begin
                        state_nxt = ST_DROP;
                        set_bad   = 1'b1;
                    end else if (mac_drop) begin
                        // Filtered frames vanish: rewind now, never report.
                        state_nxt = ST_DROP;
                        set_quiet = 1'b1;
                        rewind    = 1'b1;
                    end else if (full) begin
                        state_nxt = ST_DROP;
                        set_ovf   = 1'b1;
                    end else begin
                        wr_go = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!rxctl) state_nxt = quiet ? ST_IDLE : ST_CHECK;
            end
            ST_CHECK: begin
                report    = 1'b1;
                frm_start = rxctl;
                state_nxt = rxctl ? ST_PRE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            crc      <= CRC_INIT;
            len      <= '0;
            phase    <= 1'b0;
            low_nib  <= '0;
            wr_ptr   <= '0;
            base     <= '0;
            ovf      <= 1'b0;
            bad      <= 1'b0;
            quiet    <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            frm_done <= 1'b0;
            frm_ok   <= 1'b0;
            frm_len  <= '0;
            frm_base <= '0;
            err_cnt  <= '0;
        end else begin
            wr_en    <= 1'b0;
            frm_done <= 1'b0;
            if (frm_start) begin
                bad   <= 1'b0;
                ovf   <= 1'b0;
                quiet <= 1'b0;
                len   <= '0;
            end
            if (sfd) begin
                crc   <= CRC_INIT;
                len   <= '0;
                phase <= 1'b0;
            end
            if (crc_en)    crc <= crc_upd;
            if (latch_low) begin
                low_nib <= rxd;
                phase   <= 1'b1;
            end
            if (wr_go) begin
                wr_en   <= 1'b1;
                wr_addr <= wr_ptr;
                wr_data <= {rxd, low_nib};
                wr_ptr  <= wr_ptr_inc;
                len     <= len + 1'b1;
                phase   <= 1'b0;
            end
            if (set_bad)   bad   <= 1'b1;
            if (set_ovf)   ovf   <= 1'b1;
            if (set_quiet) quiet <= 1'b1;
            if (rewind)    wr_ptr <= base;
            if (report) begin
                frm_done <= 1'b1;
                frm_ok   <= good;
                frm_len  <= len;
                frm_base <= base;
                if (good) begin
                    base <= wr_ptr;
                end else begin
                    wr_ptr <= base;
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Scoreboard bench for rgmii_rx_framer: expected writes/reports queued at drive time.
module tb_rgmii_rx_framer;

    localparam int          ADDR_W    = 11;
    localparam int          MIN_LEN   = 64;
    localparam int          MAX_LEN   = 1518;
    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;

    logic              rxclk = 1'b0;
    logic              rst_n;
    logic              rxctl;
    logic [3:0]        rxd;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frm_done;
    logic              frm_ok;
    logic [10:0]       frm_len;
    logic [ADDR_W-1:0] frm_base;
    logic [15:0]       err_cnt;

    rgmii_rx_framer #(
        .ADDR_W    (ADDR_W),
        .MIN_LEN   (MIN_LEN),
        .MAX_LEN   (MAX_LEN),
        .LOCAL_MAC (LOCAL_MAC)
    ) dut (
        .rxclk    (rxclk),
        .rst_n    (rst_n),
        .rxctl    (rxctl),
        .rxd      (rxd),
        .rd_ptr   (rd_ptr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frm_done (frm_done),
        .frm_ok   (frm_ok),
        .frm_len  (frm_len),
        .frm_base (frm_base),
        .err_cnt  (err_cnt)
    );

    always #5 rxclk = ~rxclk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_exp_t;

    typedef struct {
        logic              ok;
        logic [10:0]       len;
        logic [ADDR_W-1:0] base;
    } rpt_exp_t;

    wr_exp_t  wq[$];
    rpt_exp_t rq[$];
    wr_exp_t  we;
    rpt_exp_t re;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]        frame [0:1599];
    logic [ADDR_W-1:0] m_wr, m_base;
    int                m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge rxclk);
        #1;
        if (rst_n) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 32'(wr_en), 0);
                end else begin
                    we = wq.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(we.addr));
                    check("wr_data", 32'(wr_data), 32'(we.data));
                end
            end
            if (frm_done) begin
                if (rq.size() == 0) begin
                    check("done_unexpected", 32'(frm_done), 0);
                end else begin
                    re = rq.pop_front();
                    check("frm_ok", 32'(frm_ok), 32'(re.ok));
                    check("frm_len", 32'(frm_len), 32'(re.len));
                    check("frm_base", 32'(frm_base), 32'(re.base));
                end
            end
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r = c;
        for (int k = 0; k < 8; k++)
            r = ((r[0] ^ b[k]) == 1'b1) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic build(input int n, input logic [47:0] dest, input bit flip);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            if (i < 6) frame[i] = dest[47 - 8*i -: 8];
            else       frame[i] = 8'(i * 7 + 3);
            c = crc_byte(c, frame[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frame[n - 4 + k] = c[8*k +: 8];
        if (flip) frame[20] = frame[20] ^ 8'h10;
    endtask

    task automatic nib(input logic [3:0] v);
        @(negedge rxclk);
        rxctl = 1'b1;
        rxd   = v;
    endtask

    task automatic do_reset();
        @(negedge rxclk);
        rst_n = 1'b0;
        rxctl = 1'b0;
        rxd   = 4'h0;
        wq.delete();
        rq.delete();
        m_wr  = '0;
        m_base = '0;
        m_err = 0;
        #2;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_frm_done", 32'(frm_done), 0);
        check("rst_frm_ok", 32'(frm_ok), 0);
        check("rst_frm_len", 32'(frm_len), 0);
        check("rst_frm_base", 32'(frm_base), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        repeat (2) @(negedge rxclk);
        rst_n = 1'b1;
        @(negedge rxclk);
    endtask

    // Drives one frame from frame[] and queues what the DUT should do with it.
    // abort_at >= 0 stops driving before that byte and queues no report.
    task automatic send(input int n, input bit odd, input bit fcs_ok, input int abort_at);
        int          len  = 0;
        bit          drop = 0;
        bit          filt = 0;
        bit          ok;
        logic [47:0] da;
        da = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
        for (int i = 0; i < 15; i++) nib(4'h5);
        nib(4'hD);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) return;
            if (!drop) begin
                if (len == MAX_LEN) begin
                    drop = 1;
`ifdef RX_MAC_FILTER_EN
                end else if (i == 5 && da != LOCAL_MAC && da != 48'hFFFF_FFFF_FFFF) begin
                    drop = 1;
                    filt = 1;
                    m_wr = m_base;
`endif
                end else if (ADDR_W'(m_wr + 1'b1) == rd_ptr) begin
                    drop = 1;
                end else begin
                    wq.push_back(wr_exp_t'{m_wr, frame[i]});
                    m_wr = m_wr + 1'b1;
                    len++;
                end
            end
            nib(frame[i][3:0]);
            nib(frame[i][7:4]);
        end
        if (odd) nib(4'h0);
        @(negedge rxclk);
        rxctl = 1'b0;
        rxd   = 4'h0;
        if (!filt) begin
            ok = fcs_ok && !drop && !odd && (len >= MIN_LEN) && (len <= MAX_LEN);
            rq.push_back(rpt_exp_t'{ok, 11'(len), m_base});
            if (ok) begin
                m_base = m_wr;
            end else begin
                m_wr = m_base;
                if (m_err < 65535) m_err++;
            end
        end
        for (int t = 0; t < 20 && rq.size() != 0; t++) @(negedge rxclk);
        check("report_drained", 32'(rq.size()), 0);
        repeat (3) @(negedge rxclk);
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("writes_drained", 32'(wq.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        rxctl  = 1'b0;
        rxd    = 4'h0;
        rd_ptr = '0;
        m_wr   = '0;
        m_base = '0;
        m_err  = 0;
        do_reset();

        build(64, LOCAL_MAC, 0);
        send(64, 0, 1, -1);

        do_reset();
        build(64, LOCAL_MAC, 1);
        send(64, 0, 0, -1);
        build(64, LOCAL_MAC, 0);
        send(64, 0, 1, -1);
        send(64, 1, 1, -1);

        do_reset();
        rd_ptr = 11'd32;
        send(64, 0, 1, -1);
        rd_ptr = '0;
        send(64, 0, 1, -1);

        build(1519, LOCAL_MAC, 0);
        send(1519, 0, 1, -1);
        build(60, LOCAL_MAC, 0);
        send(60, 0, 1, -1);

`ifdef RX_MAC_FILTER_EN
        build(64, 48'h02_00_00_00_00_05, 0);
        send(64, 0, 1, -1);
        build(64, 48'hFF_FF_FF_FF_FF_FF, 0);
        send(64, 0, 1, -1);
`endif

        build(64, LOCAL_MAC, 0);
        send(64, 0, 1, 20);
        do_reset();
        send(64, 0, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_framer.md
Name: rgmii_rx_framer

Overview:
- Receive-side Ethernet framer; counterpart of the nibble transmitter on the RGMII port (10/100 mode, one nibble per rxclk).
- Strips preamble/SFD, assembles bytes, checks FCS and length.
- Writes accepted frames into the rx-side dual-port RAM (write port, toward the DAC path) and reports each frame with a one-cycle completion pulse.
- Rejected frames are rewound out of the buffer.

Parameters:
ADDR_W, 11, RAM write-address width; the buffer is a ring of 2^ADDR_W bytes
MIN_LEN, 64, minimum legal frame length in bytes, including FCS
MAX_LEN, 1518, maximum legal frame length in bytes, including FCS
LOCAL_MAC, 48'h02_00_00_00_00_01, station address; used only with RX_MAC_FILTER_EN

Ports:
rxclk  in  1  receive clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
rxctl  in  1  RX_DV, sampled on the rising edge
rxd  in  4  receive nibble; low nibble of each byte first
rd_ptr  in  ADDR_W  consumer read pointer, used for ring-full detection
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  8  RAM write byte
frm_done  out  1  one-cycle pulse per frame reported
frm_ok  out  1  frame status, valid while frm_done=1
frm_len  out  11  byte count including FCS, valid while frm_done=1
frm_base  out  ADDR_W  address of the frame's first byte, valid while frm_done=1
err_cnt  out  16  count of rejected frames, saturating

Behaviour:
- Reset: all outputs 0; wr_ptr=0; base=0; state IDLE. Reset mid-frame abandons the frame with no report; the consumer must reset too.
- States: IDLE, PRE, DATA, DROP, CHECK.
- IDLE: rxctl=1 and rxd=5 -> PRE. rxctl=1 and any other nibble -> DROP.
- PRE: nibble 5 stays in PRE. Nibble D -> DATA (CRC=32'hFFFFFFFF, len=0, phase=0). Any other nibble -> DROP. rxctl=0 -> IDLE with no report.
- DATA, rxctl=1:
  - Every nibble updates the CRC: reflected polynomial 0xEDB88320, LSB first.
  - phase 0: latch the low nibble.
  - phase 1: form the byte {rxd, low}, assert wr_en with wr_addr=wr_ptr, then wr_ptr++ and len++.
  - Latency: the write occurs in the same cycle the high nibble is sampled (registered outputs, visible the next cycle).
- DATA, rxctl=0 -> CHECK.
- CHECK (1 cycle): frm_ok=1 only if all of the following hold:
  - CRC residue == 32'hDEBB20E3
  - phase == 0 (no odd nibble)
  - MIN_LEN <= len <= MAX_LEN
  - no overflow
- CHECK outcome, next cycle:
  - frm_done=1, frm_len=len, frm_base=base.
  - ok: base <= wr_ptr.
  - fail: wr_ptr <= base, err_cnt++ (saturates at 16'hFFFF).
- CHECK exit: rxctl=1 -> PRE; rxctl=0 -> IDLE.
- Full ring: a write where wr_ptr+1 == rd_ptr is suppressed; set overflow -> DROP.
- len would exceed MAX_LEN -> DROP without writing.
- DROP: no writes; on rxctl=0 -> CHECK, which reports failure. Frames that failed in IDLE (no valid start) are silently discarded with no report and no count.
- Ring addresses wrap modulo 2^ADDR_W; frm_len is not truncated.

Optional Feature:
- Macro: RX_MAC_FILTER_EN.
- Defined:
  - Destination bytes 0-5 are compared on the fly against LOCAL_MAC (byte 0 = MSB) and against FF:FF:FF:FF:FF:FF.
  - On mismatch after byte 5: -> DROP, wr_ptr rewound, no frm_done pulse, err_cnt unchanged.
- Undefined: all frames are accepted for checking; the comparator logic is absent.

Decomposition:
- Package eth_rx_pkg: state enum, CRC_POLY=32'hEDB88320, CRC_INIT, CRC_RESIDUE=32'hDEBB20E3, PRE_NIB=4'h5, SFD_NIB=4'hD.
- One sub-module, crc32_nib: 4-bit-per-cycle reflected CRC update; combinational next-CRC from crc_in and a nibble.

Test Plan:
- Good 64-byte frame (15x nibble 5, D, 128 data nibbles with valid FCS), rd_ptr=0 -> wr_addr 0..63 carries the bytes in order; frm_done one cycle after CHECK with frm_ok=1, frm_len=64, frm_base=0.
- Same frame with one payload bit flipped -> frm_ok=0, err_cnt=1. Then a good frame -> frm_base=0 (rewound), frm_ok=1.
- Good frame with one extra nibble (129 nibbles) -> alignment fail, frm_ok=0.
- rd_ptr=32, wr_ptr=0, 64-byte frame -> writes stop at addr 30; frm_ok=0; wr_ptr back at 0.
- 1519-byte frame -> no write past byte 1518; frm_ok=0. A 60-byte frame -> frm_ok=0, frm_len=60.
- RX_MAC_FILTER_EN: destination 02:00:00:00:00:05 -> no frm_done, err_cnt unchanged. Broadcast destination -> frm_ok=1. Separately, rst_n pulled low mid-DATA -> all outputs 0, next frame at base 0.
